// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and op-class helpers for the EX-stage ALU.
package alu_pkg;

  localparam int unsigned OP_W = 5;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD    = 5'b00000,
    ALU_SUB    = 5'b00001,
    ALU_AND    = 5'b00010,
    ALU_OR     = 5'b00011,
    ALU_XOR    = 5'b00100,
    ALU_SLT    = 5'b00101,
    ALU_SLTU   = 5'b00110,
    ALU_SLL    = 5'b00111,
    ALU_SRL    = 5'b01000,
    ALU_SRA    = 5'b01011,
    ALU_LUI    = 5'b01111,
    ALU_MUL    = 5'b10000,
    ALU_MULH   = 5'b10001,
    ALU_MULHSU = 5'b10010,
    ALU_MULHU  = 5'b10011,
    ALU_DIV    = 5'b10100,
    ALU_DIVU   = 5'b10101,
    ALU_REM    = 5'b10110,
    ALU_REMU   = 5'b10111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } alu_state_e;

  // M-extension ops live in 10xxx; 11xxx is reserved and behaves like a base op
  function automatic logic is_mext(input logic [OP_W-1:0] op);
    return op[4:3] == 2'b10;
  endfunction

  // DIV/DIVU/REM/REMU
  function automatic logic is_div(input logic [OP_W-1:0] op);
    return op[4:2] == 3'b101;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider on operand magnitudes, one quotient bit per cycle.
module div_unit
  import alu_pkg::*;
#(
  parameter int unsigned LEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           start,
  input  logic           sgn,
  input  logic [LEN-1:0] op1,
  input  logic [LEN-1:0] op2,
  output logic           busy,
  output logic           done_c,
  output logic [LEN-1:0] quot_c,
  output logic [LEN-1:0] rem_c
);

  localparam int unsigned CW = $clog2(LEN) + 1;

  logic [CW-1:0]  cnt;
  logic [LEN-1:0] dvd;
  logic [LEN-1:0] rem_r;
  logic [LEN-1:0] dvs;
  logic           q_neg;
  logic           r_neg;

  logic [LEN:0]   part_c;
  logic           lt_c;
  logic [LEN-1:0] q_next_c;
  logic [LEN-1:0] r_next_c;

  // One restoring step; results are sign-fixed so the final step lands straight in the output reg
  always_comb begin
    part_c   = {rem_r, dvd[LEN-1]};
    lt_c     = part_c < {1'b0, dvs};
    r_next_c = lt_c ? part_c[LEN-1:0] : LEN'(part_c - {1'b0, dvs});
    q_next_c = {dvd[LEN-2:0], ~lt_c};
    quot_c   = q_neg ? (~q_next_c + LEN'(1)) : q_next_c;
    rem_c    = r_neg ? (~r_next_c + LEN'(1)) : r_next_c;
    done_c   = busy & (cnt == CW'(1));
  end

  // Operand magnitude latch and iteration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt   <= '0;
      dvd   <= '0;
      rem_r <= '0;
      dvs   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (flush) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= CW'(LEN);
      dvd   <= (sgn & op1[LEN-1]) ? (~op1 + LEN'(1)) : op1;
      dvs   <= (sgn & op2[LEN-1]) ? (~op2 + LEN'(1)) : op2;
      rem_r <= '0;
      q_neg <= sgn & (op1[LEN-1] ^ op2[LEN-1]);
      r_neg <= sgn & op1[LEN-1];
    end else if (busy) begin
      dvd   <= q_next_c;
      rem_r <= r_next_c;
      cnt   <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage ALU with RV32M multiply/divide behind a req/resp handshake.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned LEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] alu_ctrl,
  input  logic [LEN-1:0]  aluop1,
  input  logic [LEN-1:0]  aluop2,
  output logic            resp_valid,
  output logic [LEN-1:0]  aluout,
  output logic            zero
);

  localparam int unsigned SHAMT_W = $clog2(LEN);
  localparam int unsigned PW      = 2 * LEN;
  localparam logic [LEN-1:0] INT_MIN = {1'b1, {(LEN-1){1'b0}}};

  alu_state_e      state;
  logic [PW-1:0]   prod;
  logic            mul_hi;
  logic            div_rem;

  logic [SHAMT_W-1:0] shamt_c;
  logic [LEN-1:0]  base_c;
  logic [PW-1:0]   ma_c, mb_c, prod_c;
  logic            accept_c, mul_op_c, div_op_c, div_zero_c, div_ovf_c, div_slow_c;
  logic [LEN-1:0]  spec_c;
  logic            load_c;
  logic [LEN-1:0]  load_val_c;

  logic            div_busy, div_done_c;
  logic [LEN-1:0]  div_quot_c, div_rem_c;

  // Single-cycle base ALU
  always_comb begin
    shamt_c = aluop2[SHAMT_W-1:0];
    base_c  = '0;
    case (alu_ctrl)
      ALU_ADD:  base_c = aluop1 + aluop2;
      ALU_SUB:  base_c = aluop1 - aluop2;
      ALU_AND:  base_c = aluop1 & aluop2;
      ALU_OR:   base_c = aluop1 | aluop2;
      ALU_XOR:  base_c = aluop1 ^ aluop2;
      ALU_SLT:  base_c = LEN'($signed(aluop1) < $signed(aluop2));
      ALU_SLTU: base_c = LEN'(aluop1 < aluop2);
      ALU_SLL:  base_c = aluop1 << shamt_c;
      ALU_SRL:  base_c = aluop1 >> shamt_c;
      ALU_SRA:  base_c = LEN'($signed(aluop1) >>> shamt_c);
      ALU_LUI:  base_c = aluop2;
      default:  base_c = '0;
    endcase
  end

  // Op classification, divide special cases and the full-width product
  always_comb begin
    accept_c   = req_valid & req_ready & ~flush;
    div_op_c   = is_div(alu_ctrl);
    mul_op_c   = is_mext(alu_ctrl) & ~div_op_c;
    div_zero_c = aluop2 == '0;
    div_ovf_c  = ~alu_ctrl[0] & (aluop1 == INT_MIN) & (aluop2 == '1);
    div_slow_c = div_op_c & ~div_zero_c & ~div_ovf_c;
    if (div_zero_c) spec_c = alu_ctrl[1] ? aluop1 : '1;
    else            spec_c = alu_ctrl[1] ? '0 : aluop1;
    // op1 is signed for MUL/MULH/MULHSU, op2 only for MULH; low half is sign-agnostic
    ma_c   = {{LEN{(alu_ctrl[1:0] != 2'b11) & aluop1[LEN-1]}}, aluop1};
    mb_c   = {{LEN{(alu_ctrl[1:0] == 2'b01) & aluop2[LEN-1]}}, aluop2};
    prod_c = ma_c * mb_c;
  end

  // Selects which value, if any, is written to aluout at the next edge
  always_comb begin
    load_c     = 1'b0;
    load_val_c = '0;
    if (!flush) begin
      case (state)
        IDLE: begin
          if (accept_c && !mul_op_c && !div_slow_c) begin
            load_c     = 1'b1;
            load_val_c = div_op_c ? spec_c : base_c;
          end
        end
        MUL: begin
          load_c     = 1'b1;
          load_val_c = mul_hi ? prod[PW-1:LEN] : prod[LEN-1:0];
        end
        DIV: begin
          if (div_done_c) begin
            load_c     = 1'b1;
            load_val_c = div_rem ? div_rem_c : div_quot_c;
          end
        end
        default: ;
      endcase
    end
  end

  div_unit #(.LEN(LEN)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (accept_c & div_slow_c),
    .sgn    (~alu_ctrl[0]),
    .op1    (aluop1),
    .op2    (aluop2),
    .busy   (div_busy),
    .done_c (div_done_c),
    .quot_c (div_quot_c),
    .rem_c  (div_rem_c)
  );

  // FSM, product register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      aluout     <= '0;
      zero       <= 1'b1;
      prod       <= '0;
      mul_hi     <= 1'b0;
      div_rem    <= 1'b0;
    end else begin
      resp_valid <= load_c;
      if (load_c) begin
        aluout <= load_val_c;
        zero   <= load_val_c == '0;
      end
      if (flush) begin
        state     <= IDLE;
        req_ready <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (accept_c && mul_op_c) begin
              state     <= MUL;
              req_ready <= 1'b0;
              prod      <= prod_c;
              mul_hi    <= alu_ctrl[1:0] != 2'b00;
            end else if (accept_c && div_slow_c) begin
              state     <= DIV;
              req_ready <= 1'b0;
              div_rem   <= alu_ctrl[1];
            end
          end
          MUL: begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
          DIV: begin
            // a divider that went idle without finishing would otherwise hang the stage
            if (div_done_c || !div_busy) begin
              state     <= IDLE;
              req_ready <= 1'b1;
            end
          end
          default: begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench: 32-bit and 8-bit instances against an arithmetic reference model.
module tb_alu_muldiv;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        v32, v8;
  logic [4:0]  alu_ctrl;
  logic [31:0] aluop1, aluop2;
  logic        rdy32, resp32, z32;
  logic [31:0] out32;
  logic        rdy8, resp8, z8;
  logic [7:0]  out8;

  bit          cur;
  logic        o_rdy, o_resp, o_z;
  logic [31:0] o_out;

  int total = 0;
  int bad   = 0;

  assign o_rdy  = cur ? rdy8  : rdy32;
  assign o_resp = cur ? resp8 : resp32;
  assign o_z    = cur ? z8    : z32;
  assign o_out  = cur ? {24'b0, out8} : out32;

  alu_muldiv dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(v32), .req_ready(rdy32),
    .alu_ctrl(alu_ctrl), .aluop1(aluop1), .aluop2(aluop2),
    .resp_valid(resp32), .aluout(out32), .zero(z32)
  );

  alu_muldiv #(.LEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(v8), .req_ready(rdy8),
    .alu_ctrl(alu_ctrl), .aluop1(aluop1[7:0]), .aluop2(aluop2[7:0]),
    .resp_valid(resp8), .aluout(out8), .zero(z8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Reference result from RISC-V arithmetic semantics on w-bit values
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] ai,
                                        input logic [31:0] bi, input int w);
    longint mask, a, b, sa, sb, r;
    int sh;
    mask = (longint'(1) << w) - 1;
    a  = longint'(ai) & mask;
    b  = longint'(bi) & mask;
    sa = (a >= (longint'(1) << (w - 1))) ? a - (longint'(1) << w) : a;
    sb = (b >= (longint'(1) << (w - 1))) ? b - (longint'(1) << w) : b;
    sh = int'(b % longint'(w));
    case (op)
      5'b00000: r = a + b;
      5'b00001: r = a - b;
      5'b00010: r = a & b;
      5'b00011: r = a | b;
      5'b00100: r = a ^ b;
      5'b00101: r = (sa < sb) ? 1 : 0;
      5'b00110: r = (a < b) ? 1 : 0;
      5'b00111: r = a << sh;
      5'b01000: r = a >> sh;
      5'b01011: r = sa >>> sh;
      5'b01111: r = b;
      5'b10000: r = sa * sb;
      5'b10001: r = (sa * sb) >> w;
      5'b10010: r = (sa * b) >> w;
      5'b10011: r = (a * b) >> w;
      5'b10100: r = (b == 0) ? -1 : sa / sb;
      5'b10101: r = (b == 0) ? -1 : a / b;
      5'b10110: r = (b == 0) ? a : sa % sb;
      5'b10111: r = (b == 0) ? a : a % b;
      default:  r = 0;
    endcase
    return 32'(r & mask);
  endfunction

  // Cycles from acceptance to the response pulse
  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] ai,
                                 input logic [31:0] bi, input int w);
    longint mask, a, b;
    mask = (longint'(1) << w) - 1;
    a = longint'(ai) & mask;
    b = longint'(bi) & mask;
    if (op[4:3] != 2'b10) return 1;
    if (!op[2]) return 2;
    if (b == 0) return 1;
    if (!op[0] && a == (longint'(1) << (w - 1)) && b == mask) return 1;
    return w + 1;
  endfunction

  function automatic logic [31:0] pick(input bit s8);
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return s8 ? 32'h80 : 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input bit sel, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int lat, w;
    bit got;
    cur = sel;
    w   = sel ? 8 : 32;
    exp = model(op, a, b, w);
    lat = exp_lat(op, a, b, w);
    @(negedge clk);
    alu_ctrl = op; aluop1 = a; aluop2 = b;
    if (sel) v8 = 1'b1; else v32 = 1'b1;
    chk({tag, "_rdy_in"}, 32'(o_rdy), 32'd1);
    @(posedge clk);
    #1 v8 = 1'b0; v32 = 1'b0;
    got = 1'b0;
    for (int k = 1; k <= lat + 2; k++) begin
      @(negedge clk);
      if (o_resp) begin
        got = 1'b1;
        chk({tag, "_lat"}, 32'(k), 32'(lat));
        chk({tag, "_out"}, o_out, exp);
        chk({tag, "_zero"}, 32'(o_z), 32'(exp == 32'd0));
        chk({tag, "_rdy_resp"}, 32'(o_rdy), 32'd1);
        break;
      end else if (k < lat) begin
        chk({tag, "_rdy_busy"}, 32'(o_rdy), 32'd0);
      end
    end
    chk({tag, "_resp_seen"}, 32'(got), 32'd1);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; flush = 1'b0; v32 = 1'b0; v8 = 1'b0; cur = 1'b0;
    alu_ctrl = '0; aluop1 = '0; aluop2 = '0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      cur = bit'(s);
      #0;
      chk("reset_rdy", 32'(o_rdy), 32'd1);
      chk("reset_resp", 32'(o_resp), 32'd0);
      chk("reset_out", o_out, 32'd0);
      chk("reset_zero", 32'(o_z), 32'd1);
    end
    rst_n = 1'b1;
    cur = 1'b0;

    // back-to-back base ops
    @(negedge clk);
    alu_ctrl = 5'b00000; aluop1 = 7; aluop2 = 5; v32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_add_resp", 32'(o_resp), 32'd1);
    chk("b2b_add_out", o_out, 32'd12);
    chk("b2b_add_zero", 32'(o_z), 32'd0);
    alu_ctrl = 5'b00001; aluop1 = 5; aluop2 = 5;
    @(posedge clk);
    #1 v32 = 1'b0;
    @(negedge clk);
    chk("b2b_sub_resp", 32'(o_resp), 32'd1);
    chk("b2b_sub_out", o_out, 32'd0);
    chk("b2b_sub_zero", 32'(o_z), 32'd1);

    // directed vectors, 32-bit
    do_op(0, 5'b10001, 32'h8000_0000, 32'h8000_0000, "mulh_min");
    do_op(0, 5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    do_op(0, 5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    do_op(0, 5'b10000, 32'h1234_5678, 32'h9ABC_DEF0, "mul");
    do_op(0, 5'b10100, 32'hFFFF_FFF9, 32'd2, "div_neg");
    do_op(0, 5'b10110, 32'hFFFF_FFF9, 32'd2, "rem_neg");
    do_op(0, 5'b10101, 32'd100, 32'd7, "divu");
    do_op(0, 5'b10100, 32'd12345, 32'd0, "div_by0");
    do_op(0, 5'b10111, 32'd9, 32'd0, "remu_by0");
    do_op(0, 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(0, 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    do_op(0, 5'b10101, 32'h8000_0000, 32'hFFFF_FFFF, "divu_nospec");
    do_op(0, 5'b01011, 32'h8000_00F0, 32'd36, "sra");
    do_op(0, 5'b11010, 32'd5, 32'd6, "rsvd");

    // directed vectors, 8-bit
    do_op(1, 5'b10001, 32'h80, 32'h80, "l8_mulh");
    do_op(1, 5'b10011, 32'hFF, 32'hFF, "l8_mulhu");
    do_op(1, 5'b10100, 32'hF9, 32'h02, "l8_div_neg");
    do_op(1, 5'b10110, 32'hF9, 32'h02, "l8_rem_neg");
    do_op(1, 5'b10101, 32'd100, 32'd7, "l8_divu");
    do_op(1, 5'b10100, 32'h80, 32'hFF, "l8_div_ovf");
    do_op(1, 5'b10100, 32'h33, 32'h00, "l8_div_by0");

    // flush mid-divide
    do_op(0, 5'b00000, 32'd3, 32'd4, "pre_flush");
    cur = 1'b0;
    cnt = 0;
    @(negedge clk);
    alu_ctrl = 5'b10101; aluop1 = 100; aluop2 = 7; v32 = 1'b1;
    @(posedge clk);
    #1 v32 = 1'b0;
    repeat (9) begin
      @(negedge clk);
      if (o_resp) cnt++;
    end
    @(negedge clk);
    if (o_resp) cnt++;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_rdy", 32'(o_rdy), 32'd1);
    chk("flush_keep_out", o_out, 32'd7);
    repeat (40) begin
      @(negedge clk);
      if (o_resp) cnt++;
    end
    chk("flush_no_resp", 32'(cnt), 32'd0);
    do_op(0, 5'b00000, 32'd1, 32'd1, "post_flush_add");

    // flush wins over a same-cycle request
    cur = 1'b0;
    @(negedge clk);
    alu_ctrl = 5'b00000; aluop1 = 3; aluop2 = 4; v32 = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 v32 = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_req_resp", 32'(o_resp), 32'd0);
    chk("flush_req_out", o_out, 32'd2);

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    alu_ctrl = 5'b10100; aluop1 = 32'hFFFF_FF00; aluop2 = 3; v32 = 1'b1;
    @(posedge clk);
    #1 v32 = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", o_out, 32'd0);
    chk("arst_zero", 32'(o_z), 32'd1);
    chk("arst_resp", 32'(o_resp), 32'd0);
    chk("arst_rdy", 32'(o_rdy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_resp) cnt++;
    end
    chk("arst_no_resp", 32'(cnt), 32'd0);

    // randomized traffic on both widths
    for (int i = 0; i < 200; i++)
      do_op(0, 5'($urandom_range(0, 31)), pick(0), pick(0), "rnd32");
    for (int i = 0; i < 200; i++)
      do_op(1, 5'($urandom_range(0, 31)), pick(1) & 32'hFF, pick(1) & 32'hFF, "rnd8");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
